// File: rtl/avalon_st_mute_switcher_pkg.sv
// Shared Avalon-ST constants and the mute-switcher state encoding.
// Imported by the selector top and reusable by neighbouring streaming blocks.
package avalon_st_mute_switcher_pkg;

  localparam int AST_ERR_W = 2;
  localparam logic [11:0] DAC_MIDSCALE_12 = 12'h800;

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_MUTE = 1'b1
  } mute_state_t;

endpackage

// File: rtl/avalon_st_mute_switcher_sync_2ff.sv
// Generic two-flop bit-vector synchroniser with asynchronous active-low reset.
// Used for switch and button inputs that arrive with no relation to clk.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/avalon_st_mute_switcher.sv
// N-channel Avalon-ST selector: synchronised channel select, and a muted run of
// MUTE_BEATS beats of the new channel after every change so the DAC never clicks.
module avalon_st_mute_switcher
  import avalon_st_mute_switcher_pkg::*;
#(
  parameter int                DATA_W     = 12,
  parameter int                NUM_CH     = 4,
  parameter int                SEL_W      = 2,
  parameter int                MUTE_BEATS = 8,
  parameter logic [DATA_W-1:0] MUTE_VALUE = DATA_W'(DAC_MIDSCALE_12)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [SEL_W-1:0]            select,
  input  logic [NUM_CH*DATA_W-1:0]    sink_data,
  input  logic [NUM_CH-1:0]           sink_valid,
  input  logic [NUM_CH*AST_ERR_W-1:0] sink_error,
  output logic [DATA_W-1:0]           source_data,
  output logic                        source_valid,
  output logic [AST_ERR_W-1:0]        source_error,
  output logic [SEL_W-1:0]            active_sel,
  output logic                        muting
);

  localparam int CNT_W  = (MUTE_BEATS > 0) ? $clog2(MUTE_BEATS + 1) : 1;
  localparam int VIDX_W = $clog2(NUM_CH);
  localparam int DIDX_W = $clog2(NUM_CH * DATA_W);
  localparam int EIDX_W = $clog2(NUM_CH * AST_ERR_W);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUTE_BEATS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W + 1)'(NUM_CH);

  logic [SEL_W-1:0]     sel_s;
  mute_state_t          state;
  logic [CNT_W-1:0]     mute_cnt;
  logic [VIDX_W-1:0]    valid_idx;
  logic [DIDX_W-1:0]    data_lsb;
  logic [EIDX_W-1:0]    err_lsb;
  logic                 beat;
  logic [DATA_W-1:0]    beat_data;
  logic [AST_ERR_W-1:0] beat_err;
  logic                 switch_req;

  sync_2ff #(.W(SEL_W)) u_sel_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (select),
    .q       (sel_s)
  );

  // Mux the active channel straight out of the flattened buses.
  assign valid_idx  = VIDX_W'(active_sel);
  assign data_lsb   = DIDX_W'(active_sel) * DIDX_W'(DATA_W);
  assign err_lsb    = EIDX_W'(active_sel) * EIDX_W'(AST_ERR_W);
  assign beat       = sink_valid[valid_idx];
  assign beat_data  = sink_data[data_lsb +: DATA_W];
  assign beat_err   = sink_error[err_lsb +: AST_ERR_W];
  assign switch_req = (sel_s != active_sel) && ({1'b0, sel_s} < CH_LIMIT);

  // A switch request overrides the mute countdown, so the mute always restarts
  // from the most recent change; a beat seen in the same cycle still uses the old route.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_PASS;
      mute_cnt     <= '0;
      active_sel   <= '0;
      source_data  <= MUTE_VALUE;
      source_valid <= 1'b0;
      source_error <= '0;
      muting       <= 1'b0;
    end else begin
      source_valid <= beat;
      if (beat) begin
        if (state == ST_MUTE) begin
          source_data  <= MUTE_VALUE;
          source_error <= '0;
        end else begin
          source_data  <= beat_data;
          source_error <= beat_err;
        end
      end

      if (switch_req) begin
        active_sel <= sel_s;
        if (MUTE_BEATS == 0) begin
          state    <= ST_PASS;
          mute_cnt <= '0;
          muting   <= 1'b0;
        end else begin
          state    <= ST_MUTE;
          mute_cnt <= CNT_LOAD;
          muting   <= 1'b1;
        end
      end else if ((state == ST_MUTE) && beat) begin
        mute_cnt <= mute_cnt - CNT_ONE;
        if (mute_cnt == CNT_ONE) begin
          state  <= ST_PASS;
          muting <= 1'b0;
        end
      end
    end
  end

endmodule
